// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle CPU main controller.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_F0   = 4'd0,
      ST_F1   = 4'd1,
      ST_DEC  = 4'd2,
      ST_MADR = 4'd3,
      ST_MRD  = 4'd4,
      ST_MWB  = 4'd5,
      ST_MWR  = 4'd6,
      ST_EXR  = 4'd7,
      ST_RWB  = 4'd8,
      ST_EXI  = 4'd9,
      ST_IWB  = 4'd10,
      ST_BR   = 4'd11,
      ST_JMP  = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_CMPEQ = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Per-state Moore control word; ir_wr and the fetch pc_wr are handled in the top.
   typedef struct packed {
      logic       pc_wr;
      logic       pc_wr_cond;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_rd;
      logic       mem_wr;
      logic       a_wr;
      logic       b_wr;
      logic       alu_oe;
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_wr;
      logic       reg_dst;
      logic       mem_to_reg;
   } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational map from controller state to its control word.
module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  state_e     state,
   output ctrl_word_t cw
);

   // Decode one state into the datapath controls it asserts; everything else stays 0.
   always_comb begin
      cw = '0;
      case (state)
         ST_F0: begin
            cw.mem_rd = 1'b1;
         end
         ST_F1: begin
            cw.mem_rd    = 1'b1;
            cw.alu_src_b = SRCB_FOUR;
            cw.alu_op    = ALUOP_ADD;
            cw.alu_oe    = 1'b1;
            cw.pc_src    = PCSRC_ALU;
         end
         ST_DEC: begin
            cw.a_wr      = 1'b1;
            cw.b_wr      = 1'b1;
            cw.alu_src_b = SRCB_IMM_SH;
            cw.alu_op    = ALUOP_ADD;
            cw.alu_oe    = 1'b1;
         end
         ST_MADR: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_IMM;
            cw.alu_op    = ALUOP_ADD;
            cw.alu_oe    = 1'b1;
         end
         ST_MRD: begin
            cw.mem_rd = 1'b1;
            cw.iord   = 1'b1;
            cw.alu_oe = 1'b1;
         end
         ST_MWB: begin
            cw.reg_wr     = 1'b1;
            cw.mem_to_reg = 1'b1;
         end
         ST_MWR: begin
            cw.mem_wr = 1'b1;
            cw.iord   = 1'b1;
            cw.alu_oe = 1'b1;
         end
         ST_EXR: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_B;
            cw.alu_op    = ALUOP_FUNCT;
            cw.alu_oe    = 1'b1;
         end
         ST_RWB: begin
            cw.reg_wr  = 1'b1;
            cw.reg_dst = 1'b1;
            cw.alu_oe  = 1'b1;
         end
         ST_EXI: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_IMM;
            cw.alu_op    = ALUOP_ADD;
            cw.alu_oe    = 1'b1;
         end
         ST_IWB: begin
            cw.reg_wr = 1'b1;
            cw.alu_oe = 1'b1;
         end
         ST_BR: begin
            // alu_oe stays low so ALUOut still holds the target computed in DEC.
            cw.alu_src_a  = 1'b1;
            cw.alu_src_b  = SRCB_B;
            cw.alu_op     = ALUOP_CMPEQ;
            cw.pc_wr_cond = 1'b1;
            cw.pc_src     = PCSRC_ALUOUT;
         end
         ST_JMP: begin
            cw.pc_wr  = 1'b1;
            cw.pc_src = PCSRC_JUMP;
         end
         default: begin
            cw = '0;
         end
      endcase
   end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multicycle CPU: fetch, decode, execute, memory, write-back.
//
//   state | meaning
//   F0    | alu_oe low gap, memory read of PC issued
//   F1    | instruction fetch, PC+4; waits on mem_ready
//   DEC   | latch A/B, branch target into ALUOut, dispatch on opcode
//   MADR  | lw/sw address calculation
//   MRD   | data read; waits on mem_ready
//   MWB   | load write-back
//   MWR   | data write; waits on mem_ready
//   EXR   | R-type execute
//   RWB   | R-type write-back (rd)
//   EXI   | addi execute
//   IWB   | addi write-back (rt)
//   BR    | beq compare, conditional PC write
//   JMP   | jump, unconditional PC write
module mc_main_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       ir_wr,
   output logic       pc_wr,
   output logic       pc_wr_cond,
   output logic [1:0] pc_src,
   output logic       iord,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       a_wr,
   output logic       b_wr,
   output logic       alu_oe,
   output logic [1:0] alu_op,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       reg_wr,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       instr_done,
   output logic       illegal_op
);

   state_e     state_q;
   state_e     state_nxt;
   ctrl_word_t cw_nxt;
   ctrl_word_t cw_q;
   logic       is_sw_q;
   logic       illegal_set;

   mc_ctrl_outdec u_outdec (
      .state (state_nxt),
      .cw    (cw_nxt)
   );

   // Next-state logic; opcode is only looked at in DEC.
   always_comb begin
      state_nxt   = state_q;
      illegal_set = 1'b0;
      case (state_q)
         ST_F0:   state_nxt = ST_F1;
         ST_F1:   state_nxt = mem_ready ? ST_DEC : ST_F1;
         ST_DEC: begin
            case (opcode)
               OP_RTYPE:     state_nxt = ST_EXR;
               OP_LW, OP_SW: state_nxt = ST_MADR;
               OP_ADDI:      state_nxt = ST_EXI;
               OP_BEQ:       state_nxt = ST_BR;
               OP_J:         state_nxt = ST_JMP;
               default: begin
                  state_nxt   = ST_F0;
                  illegal_set = 1'b1;
               end
            endcase
         end
         ST_MADR: state_nxt = is_sw_q ? ST_MWR : ST_MRD;
         ST_MRD:  state_nxt = mem_ready ? ST_MWB : ST_MRD;
         ST_MWB:  state_nxt = ST_F0;
         ST_MWR:  state_nxt = mem_ready ? ST_F0 : ST_MWR;
         ST_EXR:  state_nxt = ST_RWB;
         ST_RWB:  state_nxt = ST_F0;
         ST_EXI:  state_nxt = ST_IWB;
         ST_IWB:  state_nxt = ST_F0;
         ST_BR:   state_nxt = ST_F0;
         ST_JMP:  state_nxt = ST_F0;
         default: state_nxt = ST_F0;
      endcase
   end

   // State, registered control word, lw/sw memo and sticky illegal flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_F0;
         cw_q       <= '0;
         is_sw_q    <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cw_q    <= cw_nxt;
         // MADR needs to know lw vs sw after opcode is no longer guaranteed.
         if (state_q == ST_DEC) begin
            is_sw_q <= (opcode == OP_SW);
         end
         if (illegal_set) begin
            illegal_op <= 1'b1;
         end
      end
   end

   // Drive outputs from the registered word; fetch completion strobes follow mem_ready.
   always_comb begin
      ir_wr      = (state_q == ST_F1) && mem_ready;
      pc_wr      = cw_q.pc_wr | ((state_q == ST_F1) && mem_ready);
      pc_wr_cond = cw_q.pc_wr_cond;
      pc_src     = cw_q.pc_src;
      iord       = cw_q.iord;
      mem_rd     = cw_q.mem_rd;
      mem_wr     = cw_q.mem_wr;
      a_wr       = cw_q.a_wr;
      b_wr       = cw_q.b_wr;
      alu_oe     = cw_q.alu_oe;
      alu_op     = cw_q.alu_op;
      alu_src_a  = cw_q.alu_src_a;
      alu_src_b  = cw_q.alu_src_b;
      reg_wr     = cw_q.reg_wr;
      reg_dst    = cw_q.reg_dst;
      mem_to_reg = cw_q.mem_to_reg;
      // Retire whenever we are heading back to F0, except the illegal-opcode bounce from DEC.
      instr_done = (state_nxt == ST_F0) && (state_q != ST_DEC);
   end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed self-checking bench for mc_main_ctrl.
module tb_mc_main_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       ir_wr, pc_wr, pc_wr_cond, iord, mem_rd, mem_wr, a_wr, b_wr, alu_oe;
   logic       alu_src_a, reg_wr, reg_dst, mem_to_reg, instr_done, illegal_op;
   logic [1:0] pc_src, alu_op, alu_src_b;
   logic [20:0] obs;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mc_main_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .ir_wr      (ir_wr),
      .pc_wr      (pc_wr),
      .pc_wr_cond (pc_wr_cond),
      .pc_src     (pc_src),
      .iord       (iord),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .a_wr       (a_wr),
      .b_wr       (b_wr),
      .alu_oe     (alu_oe),
      .alu_op     (alu_op),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .reg_wr     (reg_wr),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .instr_done (instr_done),
      .illegal_op (illegal_op)
   );

   // {ir_wr,pc_wr,pc_wr_cond,pc_src,iord,mem_rd,mem_wr,a_wr,b_wr,alu_oe,alu_op,alu_src_a,alu_src_b,reg_wr,reg_dst,mem_to_reg,instr_done,illegal_op}
   assign obs = {ir_wr, pc_wr, pc_wr_cond, pc_src, iord, mem_rd, mem_wr, a_wr, b_wr, alu_oe,
                 alu_op, alu_src_a, alu_src_b, reg_wr, reg_dst, mem_to_reg, instr_done, illegal_op};

   localparam logic [20:0] E_ZERO = 21'd0;
   //                         ir   pcw  pcc  pcs   iord mrd  mwr  a    b    oe   aop   sa   sb    rw   rd   m2r  done ill
   localparam logic [20:0] E_F0   = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [20:0] E_F1W  = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [20:0] E_F1R  = {1'b1,1'b1,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [20:0] E_DEC  = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,2'b00,1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [20:0] E_MADR = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [20:0] E_MRD  = {1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [20:0] E_MWB  = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,1'b0,1'b1,1'b1,1'b0};
   localparam logic [20:0] E_MWRW = {1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [20:0] E_MWRR = {1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0};
   localparam logic [20:0] E_EXR  = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [20:0] E_RWB  = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b1,1'b1,1'b0,1'b1,1'b0};
   localparam logic [20:0] E_EXI  = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [20:0] E_IWB  = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b1,1'b0,1'b0,1'b1,1'b0};
   localparam logic [20:0] E_BR   = {1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0};
   localparam logic [20:0] E_JMP  = {1'b0,1'b1,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0};
   localparam logic [20:0] ILL    = 21'd1;

   task automatic test_reset();
      rst_n     = 1'b0;
      opcode    = 6'b000000;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== E_ZERO) begin
         failures++;
         $display("FAIL reset_outputs obs=%h exp=%h", obs, E_ZERO);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_rtype();
      logic [20:0] ev  [5];
      logic        rdy [5];
      ev  = '{E_ZERO, E_F1R, E_DEC, E_EXR, E_RWB};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      opcode = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         mem_ready = rdy[i];
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL rtype cyc%0d obs=%h exp=%h", i + 1, obs, ev[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_lw_wait();
      logic [20:0] ev  [9];
      logic        rdy [9];
      ev  = '{E_F0, E_F1R, E_DEC, E_MADR, E_MRD, E_MRD, E_MRD, E_MRD, E_MWB};
      rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      opcode = 6'b100011;
      for (int i = 0; i < 9; i++) begin
         mem_ready = rdy[i];
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL lw_wait cyc%0d obs=%h exp=%h", i + 1, obs, ev[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sw_fetch_wait();
      logic [20:0] ev  [7];
      logic        rdy [7];
      ev  = '{E_F0, E_F1W, E_F1R, E_DEC, E_MADR, E_MWRW, E_MWRR};
      rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      opcode = 6'b101011;
      for (int i = 0; i < 7; i++) begin
         mem_ready = rdy[i];
         // after DEC the opcode bus may wander; MADR must still pick the sw path
         if (i == 4) opcode = 6'b100011;
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL sw_wait cyc%0d obs=%h exp=%h", i + 1, obs, ev[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_addi();
      logic [20:0] ev [5];
      ev = '{E_F0, E_F1R, E_DEC, E_EXI, E_IWB};
      opcode = 6'b001000;
      for (int i = 0; i < 5; i++) begin
         mem_ready = (i == 3) ? 1'b0 : 1'b1;
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL addi cyc%0d obs=%h exp=%h", i + 1, obs, ev[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_beq();
      logic [20:0] ev [4];
      logic [5:0]  op [4];
      ev = '{E_F0, E_F1R, E_DEC, E_BR};
      op = '{6'b000000, 6'b000000, 6'b000100, 6'b000000};
      for (int i = 0; i < 4; i++) begin
         opcode    = op[i];
         mem_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL beq cyc%0d obs=%h exp=%h", i + 1, obs, ev[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_jump();
      logic [20:0] ev [5];
      ev = '{E_F0, E_F1R, E_DEC, E_JMP, E_F0};
      opcode = 6'b000010;
      for (int i = 0; i < 5; i++) begin
         mem_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL jump cyc%0d obs=%h exp=%h", i + 1, obs, ev[i]);
         end
         if (i < 4) begin
            @(posedge clk); #1;
         end
      end
      // the trailing F0 check already sat in F0; step to the next cycle's F1
      @(posedge clk); #1;
   endtask

   task automatic test_illegal();
      logic [20:0] ev [7];
      logic [5:0]  op [7];
      // entered in F1 (jump task ended after its F0 cycle)
      ev = '{E_F1R, E_DEC, E_F0 | ILL, E_F1R | ILL, E_DEC | ILL, E_JMP | ILL, E_F0 | ILL};
      op = '{6'b111111, 6'b111111, 6'b000010, 6'b000010, 6'b000010, 6'b000010, 6'b000010};
      for (int i = 0; i < 7; i++) begin
         opcode    = op[i];
         mem_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL illegal cyc%0d obs=%h exp=%h", i + 1, obs, ev[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_mwr();
      logic [20:0] ev  [4];
      logic        rdy [4];
      // entered in F1 with illegal_op still set
      ev  = '{E_F1R | ILL, E_DEC | ILL, E_MADR | ILL, E_MWRW | ILL};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
      opcode = 6'b101011;
      for (int i = 0; i < 4; i++) begin
         mem_ready = rdy[i];
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL mid_mwr_pre cyc%0d obs=%h exp=%h", i + 1, obs, ev[i]);
         end
         @(posedge clk); #1;
      end
      // still in MWR waiting; pull reset between clock edges
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== E_ZERO) begin
         failures++;
         $display("FAIL mid_mwr_async obs=%h exp=%h", obs, E_ZERO);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      ev  = '{E_ZERO, E_F1R, E_DEC, E_JMP};
      opcode = 6'b000010;
      for (int i = 0; i < 4; i++) begin
         mem_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL mid_mwr_post cyc%0d obs=%h exp=%h", i + 1, obs, ev[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      opcode    = 6'b000000;
      mem_ready = 1'b0;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_sw_fetch_wait();
      test_addi();
      test_beq();
      test_jump();
      test_illegal();
      test_reset_mid_mwr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_main_ctrl.md
# mc_main_ctrl

Main control state machine for the multicycle CPU. It decodes the instruction opcode and sequences the datapath: fetch, decode, execute, memory access and write-back. It drives the operand-latch strobes, the ALU output-enable, the `alu_op` field consumed by the ALU control decoder, and all mux selects and write enables. It consumes the ALU `Z` flag only through the datapath's branch gating.

## Interface
- No parameters; all encodings are fixed in the shared package.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `mem_ready` in 1: memory handshake; the access completes in the cycle it is high.
- `ir_wr` out 1: IR load enable.
- `pc_wr` out 1: unconditional PC write.
- `pc_wr_cond` out 1: PC write qualified by `Z` in the datapath.
- `pc_src` out 2: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `mem_rd` out 1; `mem_wr` out 1: memory read and write requests.
- `a_wr` out 1; `b_wr` out 1: operand-latch strobes; the latch captures on the rising edge.
- `alu_oe` out 1: ALU result drive; the ALU latches its output on the rising edge and releases it on the falling edge.
- `alu_op` out 2: 00 add, 01 compare-equal, 10 decode funct.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- `reg_wr` out 1; `reg_dst` out 1 (1 = rd); `mem_to_reg` out 1: register-file write controls.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `illegal_op` out 1: sticky flag, set on an unknown opcode.

## Operation
- States: F0, F1, DEC, MADR, MRD, MWB, MWR, EXR, RWB, EXI, IWB, BR, JMP.
- Outputs are Moore and registered, decoded from the next state, so they are glitch-free; this matters for the edge-sensitive `a_wr`, `b_wr` and `alu_oe`.
- Exceptions: `ir_wr` and `pc_wr` in F1 are `state==F1 & mem_ready`.
- F0: `mem_rd`=1, `iord`=0, `alu_oe`=0. Next state F1.
- F1: `mem_rd`=1, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `alu_oe`=1, `pc_src`=00. Stay while `mem_ready`=0; go to DEC when it is 1.
- DEC: `a_wr`=`b_wr`=1, `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00, `alu_oe`=1 (branch target). Dispatch on `opcode`:
  - 000000 → EXR
  - 100011 or 101011 → MADR
  - 001000 → EXI
  - 000100 → BR
  - 000010 → JMP
  - anything else → F0, set `illegal_op`, no `instr_done`.
- MADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00, `alu_oe`=1. Go to MRD for lw, MWR for sw.
- MRD: `mem_rd`=1, `iord`=1, `alu_oe`=1. Wait for `mem_ready`, then MWB.
- MWB: `reg_wr`=1, `reg_dst`=0, `mem_to_reg`=1. Next state F0.
- MWR: `mem_wr`=1, `iord`=1, `alu_oe`=1. Wait for `mem_ready`, then F0.
- EXR: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10, `alu_oe`=1. Next state RWB.
- RWB: `reg_wr`=1, `reg_dst`=1, `mem_to_reg`=0, `alu_oe`=1. Next state F0.
- EXI: as EXR but `alu_src_b`=10, `alu_op`=00. Next state IWB.
- IWB: as RWB but `reg_dst`=0.
- BR: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_wr_cond`=1, `pc_src`=01. `alu_oe`=0, so ALUOut keeps the target from DEC. Next state F0.
- JMP: `pc_wr`=1, `pc_src`=10. Next state F0.
- `instr_done` pulses in the cycle whose next state is F0, except for the illegal-opcode path.

## Timing
- Reset: the state goes to F0 immediately; every output is 0, including `illegal_op`.
- Reset mid-access (MRD/MWR): the request drops asynchronously and no write occurs.
- F0 exists so that `alu_oe` falls for at least one cycle before each fetch. Every ALU use therefore sees a fresh rising edge.
- `a_wr`/`b_wr` are high for exactly one cycle per instruction.
- CPI with zero-wait memory (`mem_ready` tied high):
  - R-type 5; addi 5; lw 6; sw 5; beq 4; j 4.
  - Each memory wait cycle adds 1.
- `opcode` is sampled only in DEC. Changes in other states are ignored.
- `mem_ready` is ignored outside F1, MRD and MWR.
- `illegal_op` clears only on reset.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - the state enum (4-bit);
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_ADDI`, `OP_BEQ`, `OP_J`;
  - `alu_op`, `alu_src_b` and `pc_src` encodings;
  - the control-word struct.
- One sub-module, `mc_ctrl_outdec`: a combinational map from state to control word. The top registers its output on the next state.

## Test plan
- R-type: reset, `mem_ready`=1, `opcode`=000000. Expect the sequence F0,F1,DEC,EXR,RWB. `a_wr` pulses once in DEC; `alu_op`=10 in EXR; `reg_wr`=1 and `reg_dst`=1 in RWB; `instr_done` at cycle 5.
- lw with `mem_ready` low for 3 cycles in MRD: MRD holds 4 cycles with `iord`=1 and `mem_rd`=1. MWB has `mem_to_reg`=1. Total 9 cycles.
- beq: `pc_wr_cond`=1, `pc_src`=01, `alu_op`=01 for exactly one cycle; `alu_oe`=0 in BR; total 4 cycles.
- j: `pc_wr`=1 with `pc_src`=10 in JMP; no `reg_wr` anywhere in the instruction.
- Illegal `opcode`=111111: after DEC, `illegal_op`=1 and the state returns to F0. There is no `instr_done`, and the next fetch proceeds normally.
- Reset asserted mid-MWR: `mem_wr` drops to 0 without waiting for a clock. After release the FSM starts at F0 with all outputs 0.
